// File: rtl/display_text_buffer.sv
// rtl/display_text_buffer.sv - character console text store with cursor and row/screen clear sequencer
module display_text_buffer #(
  parameter int         ROWS          = 41,
  parameter int         WORDS_PER_ROW = 8,
  parameter logic [7:0] BLANK         = 8'h20
) (
  input  logic        VGA_CLK_IN,
  input  logic        rst,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [31:0] displayAsquiiAux [ROWS*WORDS_PER_ROW-1:0],
  output logic [5:0]  cursor_row,
  output logic [4:0]  cursor_col,
  output logic        busy
);

  localparam int          NUM_WORDS  = ROWS * WORDS_PER_ROW;
  localparam logic [5:0]  LAST_ROW   = 6'(ROWS - 1);
  localparam logic [4:0]  LAST_COL   = 5'(WORDS_PER_ROW * 4 - 1);
  localparam logic [8:0]  LAST_WORD  = 9'(NUM_WORDS - 1);
  localparam logic [31:0] BLANK_WORD = {4{BLANK}};

  typedef enum logic [1:0] {IDLE, CLR_ROW, CLR_ALL} state_t;

  state_t     state;
  logic [8:0] clr_ptr;
  logic [8:0] clr_last;

  logic       printable;
  logic       line_feed;
  logic       take;
  logic [5:0] row_next;
  logic [5:0] bs_row;
  logic [4:0] bs_col;
  logic [8:0] cur_idx;
  logic [8:0] bs_idx;

  function automatic logic [8:0] word_index(input logic [5:0] r, input logic [4:0] c);
    return 9'(r) * 9'(WORDS_PER_ROW) + 9'(c[4:2]);
  endfunction

  // Column 0 of a word lives in its most significant byte.
  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] c,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (c)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

  assign char_ready = (state == IDLE);
  assign busy       = !char_ready;
  assign take       = char_valid && char_ready;

  always_comb begin
    printable = (char_in >= 8'h20) && (char_in <= 8'h7E);
    line_feed = printable ? (cursor_col == LAST_COL) : (char_in == 8'h0A);
    row_next  = (cursor_row == LAST_ROW) ? 6'd0 : cursor_row + 6'd1;
    if (cursor_col != 5'd0) begin
      bs_row = cursor_row;
      bs_col = cursor_col - 5'd1;
    end else if (cursor_row != 6'd0) begin
      bs_row = cursor_row - 6'd1;
      bs_col = LAST_COL;
    end else begin
      bs_row = 6'd0;
      bs_col = 5'd0;
    end
    cur_idx = word_index(cursor_row, cursor_col);
    bs_idx  = word_index(bs_row, bs_col);
  end

  always_ff @(posedge VGA_CLK_IN) begin
    if (rst) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        displayAsquiiAux[i] <= BLANK_WORD;
      end
      cursor_row <= 6'd0;
      cursor_col <= 5'd0;
      state      <= IDLE;
      clr_ptr    <= 9'd0;
      clr_last   <= 9'd0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            if (printable) begin
              displayAsquiiAux[cur_idx] <= put_byte(displayAsquiiAux[cur_idx], cursor_col[1:0], char_in);
              if (!line_feed) begin
                cursor_col <= cursor_col + 5'd1;
              end
            end
            // Newline and column wrap share the same row advance and row clear.
            if (line_feed) begin
              cursor_col <= 5'd0;
              cursor_row <= row_next;
              clr_ptr    <= word_index(row_next, 5'd0);
              clr_last   <= word_index(row_next, LAST_COL);
              state      <= CLR_ROW;
            end
            if (char_in == 8'h08) begin
              cursor_row             <= bs_row;
              cursor_col             <= bs_col;
              displayAsquiiAux[bs_idx] <= put_byte(displayAsquiiAux[bs_idx], bs_col[1:0], BLANK);
            end
            if (char_in == 8'h0C) begin
              cursor_row <= 6'd0;
              cursor_col <= 5'd0;
              clr_ptr    <= 9'd0;
              clr_last   <= LAST_WORD;
              state      <= CLR_ALL;
            end
          end
        end
        default: begin
          displayAsquiiAux[clr_ptr] <= BLANK_WORD;
          if (clr_ptr == clr_last) begin
            state <= IDLE;
          end else begin
            clr_ptr <= clr_ptr + 9'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_text_buffer.sv
// tb/tb_display_text_buffer.sv - self-checking bench for display_text_buffer
module tb_display_text_buffer;

  localparam int NW = 328;
  localparam int NC = NW * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [31:0] disp [327:0];
  logic [5:0]  cursor_row;
  logic [4:0]  cursor_col;
  logic        busy;

  int checks = 0;
  int failures = 0;

  // Screen model: one byte per character cell, plus a queue of words still to blank.
  logic [7:0] m_chr [0:NC-1];
  int         m_row = 0;
  int         m_col = 0;
  int         mq[$];
  bit         m_live = 1'b0;

  display_text_buffer dut (
    .VGA_CLK_IN       (clk),
    .rst              (rst),
    .char_in          (char_in),
    .char_valid       (char_valid),
    .char_ready       (char_ready),
    .displayAsquiiAux (disp),
    .cursor_row       (cursor_row),
    .cursor_col       (cursor_col),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int w);
    return {m_chr[4*w], m_chr[4*w+1], m_chr[4*w+2], m_chr[4*w+3]};
  endfunction

  task automatic new_line();
    m_col = 0;
    m_row = (m_row == 40) ? 0 : m_row + 1;
    for (int i = 0; i < 8; i++) mq.push_back(m_row * 8 + i);
  endtask

  task automatic model_edge(input bit r, input bit v, input logic [7:0] c);
    int w;
    if (r) begin
      for (int i = 0; i < NC; i++) m_chr[i] = 8'h20;
      m_row = 0;
      m_col = 0;
      mq.delete();
      m_live = 1'b1;
    end else if (mq.size() != 0) begin
      w = mq.pop_front();
      for (int i = 0; i < 4; i++) m_chr[4*w+i] = 8'h20;
    end else if (v) begin
      if (c >= 8'h20 && c <= 8'h7E) begin
        m_chr[m_row*32 + m_col] = c;
        if (m_col < 31) m_col++;
        else new_line();
      end else if (c == 8'h0A) begin
        new_line();
      end else if (c == 8'h08) begin
        if (m_col > 0) m_col--;
        else if (m_row > 0) begin
          m_row--;
          m_col = 31;
        end
        m_chr[m_row*32 + m_col] = 8'h20;
      end else if (c == 8'h0C) begin
        m_row = 0;
        m_col = 0;
        for (int i = 0; i < NW; i++) mq.push_back(i);
      end
    end
  endtask

  always @(negedge clk) begin
    int bad;
    if (m_live) begin
      chk("char_ready", {31'd0, char_ready}, {31'd0, mq.size() == 0});
      chk("busy", {31'd0, busy}, {31'd0, mq.size() != 0});
      chk("cursor_row", {26'd0, cursor_row}, m_row);
      chk("cursor_col", {27'd0, cursor_col}, m_col);
      bad = 0;
      for (int i = 0; i < NW; i++) begin
        if (bad == 0 && disp[i] !== exp_word(i)) bad = i + 1;
      end
      if (bad == 0) chk("words", disp[0], exp_word(0));
      else chk($sformatf("word[%0d]", bad - 1), disp[bad-1], exp_word(bad - 1));
    end
  end

  task automatic tick(input bit r, input bit v, input logic [7:0] c);
    rst = r;
    char_valid = v;
    char_in = c;
    @(posedge clk);
    model_edge(r, v, c);
    @(negedge clk);
  endtask

  // Hold valid until the model says the byte is taken; exercises held valid during clears.
  task automatic send(input logic [7:0] c);
    bit was_idle;
    for (int n = 0; n < 1000; n++) begin
      was_idle = (mq.size() == 0);
      tick(1'b0, 1'b1, c);
      if (was_idle) return;
    end
    chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic count_busy(input string name, input int exp);
    int n;
    n = 0;
    while (char_ready == 1'b0 && n < 400) begin
      n++;
      tick(1'b0, 1'b0, 8'h00);
    end
    chk(name, n, exp);
  endtask

  task automatic fill_z();
    for (int i = 0; i < NC - 1; i++) send("Z");
  endtask

  initial begin
    logic [31:0] txt;
    #1;
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, "A");
    chk("reset_word0", disp[0], 32'h20202020);
    chk("reset_word327", disp[327], 32'h20202020);
    chk("reset_cursor", {cursor_row, cursor_col}, 11'd0);
    chk("reset_ready", {31'd0, char_ready}, 32'd1);

    txt = "ABCD";
    for (int i = 3; i >= 0; i--) send(txt[8*i +: 8]);
    send("E");
    chk("text_word0", disp[0], 32'h41424344);
    chk("text_word1", disp[1], 32'h45202020);
    chk("text_cursor", {cursor_row, cursor_col}, {6'd0, 5'd5});

    send(8'h01);
    send(8'h7F);
    send(8'hFF);
    chk("discard_cursor", {cursor_row, cursor_col}, {6'd0, 5'd5});

    for (int i = 0; i < 3; i++) send(8'h0A);
    for (int i = 0; i < 32; i++) send("x");
    for (int w = 24; w < 32; w++) chk($sformatf("wrap_word%0d", w), disp[w], 32'h78787878);
    chk("wrap_cursor", {cursor_row, cursor_col}, {6'd4, 5'd0});
    count_busy("row_clear_cycles", 8);
    chk("wrap_word32", disp[32], 32'h20202020);

    send(8'h08);
    chk("bs_row_cursor", {cursor_row, cursor_col}, {6'd3, 5'd31});
    chk("bs_row_word31", disp[31], 32'h78787820);
    send(8'h08);
    chk("bs_col_word31", disp[31], 32'h78782020);

    for (int i = 0; i < 37; i++) send(8'h0A);
    send("Q");
    chk("row40_cursor", {cursor_row, cursor_col}, {6'd40, 5'd1});
    send(8'h0A);
    chk("rowwrap_cursor", {cursor_row, cursor_col}, 11'd0);
    count_busy("rowwrap_clear_cycles", 8);
    chk("rowwrap_word0", disp[0], 32'h20202020);
    chk("rowwrap_word320", disp[320], 32'h51202020);

    send("K");
    send(8'h08);
    send(8'h08);
    chk("bs_origin_cursor", {cursor_row, cursor_col}, 11'd0);
    chk("bs_origin_word0", disp[0], 32'h20202020);

    fill_z();
    chk("fill_word0", disp[0], 32'h5A5A5A5A);
    chk("fill_word327", disp[327], 32'h5A5A5A20);
    send(8'h0C);
    count_busy("ff_clear_cycles", 328);
    chk("ff_word0", disp[0], 32'h20202020);
    chk("ff_word327", disp[327], 32'h20202020);

    fill_z();
    send(8'h0C);
    for (int i = 0; i < 99; i++) tick(1'b0, 1'b0, 8'h00);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    tick(1'b1, 1'b1, "Q");
    chk("abort_ready", {31'd0, char_ready}, 32'd1);
    chk("abort_word327", disp[327], 32'h20202020);
    chk("abort_word0", disp[0], 32'h20202020);
    chk("abort_cursor", {cursor_row, cursor_col}, 11'd0);
    tick(1'b0, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
